// File: rtl/controller_pkg.sv
// Shared types and defaults for the serial game-controller poller.
// Holds the poll state encoding and the parameter legality check used at elaboration.
package controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_CLK_LO,
        ST_CLK_HI,
        ST_DONE
    } poll_state_e;

    localparam int DEF_N_CH     = 2;
    localparam int DEF_BITS     = 16;
    localparam int DEF_HALF_DIV = 300;

    // HALF_DIV below 4 would let a bit change inside the 2-flop synchronizer window.
    function automatic bit params_ok(input int n_ch, input int bits, input int half_div);
        return (n_ch >= 1) && (bits >= 1) && (half_div >= 4);
    endfunction

endpackage

// File: rtl/ctrl_tick_gen.sv
// Free-running protocol half-period timer: pulses tick for one PCLK cycle every
// HALF_DIV cycles, restarting from zero whenever clear is asserted.
module ctrl_tick_gen #(
    parameter int HALF_DIV = 300
) (
    input  logic PCLK,
    input  logic PRESERN,
    input  logic clear,
    output logic tick
);

    localparam int             CW   = $clog2(HALF_DIV);
    localparam logic [CW-1:0]  LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/multi_controller_poller.sv
// Polls N_CH serial game controllers over a shared latch/clock pair and presents
// their active-high button state atomically, with a start/busy/done handshake.
module multi_controller_poller
    import controller_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int BITS     = DEF_BITS,
    parameter int HALF_DIV = DEF_HALF_DIV
) (
    input  logic                 PCLK,
    input  logic                 PRESERN,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [N_CH*BITS-1:0] buttons,
    output logic                 cont_latch,
    output logic                 cont_clk,
    input  logic [N_CH-1:0]      cont_data
);

    if (!params_ok(N_CH, BITS, HALF_DIV)) begin : g_bad_params
        $error("multi_controller_poller: requires N_CH>=1, BITS>=1, HALF_DIV>=4");
    end

    localparam int                IDX_W    = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BITS - 1);

    poll_state_e            state_q, state_d;
    logic                   latch_half_q, latch_half_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [N_CH-1:0]        sync1_q, sync2_q;
    logic [N_CH*BITS-1:0]   shadow_q, shadow_d;
    logic [N_CH*BITS-1:0]   buttons_q, buttons_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   cont_latch_q, cont_latch_d;
    logic                   cont_clk_q, cont_clk_d;

    logic                   tick;
    logic                   tick_clear;
    logic                   capture;

    ctrl_tick_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_tick_gen (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .clear   (tick_clear),
        .tick    (tick)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        latch_half_d = latch_half_q;
        bit_idx_d    = bit_idx_q;
        tick_clear   = 1'b0;
        capture      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tick_clear   = 1'b1;
                    latch_half_d = 1'b0;
                    state_d      = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    if (latch_half_q) begin
                        latch_half_d = 1'b0;
                        bit_idx_d    = '0;
                        capture      = 1'b1;
                        state_d      = ST_CLK_LO;
                    end else begin
                        latch_half_d = 1'b1;
                    end
                end
            end
            ST_CLK_LO: begin
                if (tick) begin
                    state_d = ST_CLK_HI;
                end
            end
            ST_CLK_HI: begin
                if (tick) begin
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        capture   = 1'b1;
                        state_d   = ST_CLK_LO;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bit k is captured as the FSM enters its low phase; data is active low on the wire.
    always_comb begin
        shadow_d = shadow_q;
        if (capture) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                shadow_d[ch*BITS + int'(bit_idx_d)] = ~sync2_q[ch];
            end
        end
    end

    // Pins and handshake are registered from the current state, one cycle behind it.
    always_comb begin
        busy_d       = (state_q != ST_IDLE);
        done_d       = (state_q == ST_DONE);
        cont_latch_d = (state_q == ST_LATCH);
        cont_clk_d   = (state_q != ST_CLK_LO);
        buttons_d    = (state_q == ST_DONE) ? shadow_q : buttons_q;
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q      <= ST_IDLE;
            latch_half_q <= 1'b0;
            bit_idx_q    <= '0;
            shadow_q     <= '0;
        end else begin
            state_q      <= state_d;
            latch_half_q <= latch_half_d;
            bit_idx_q    <= bit_idx_d;
            shadow_q     <= shadow_d;
        end
    end

    // Released (not pressed) is the safe value while the synchronizer refills.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= cont_data;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cont_latch_q <= 1'b0;
            cont_clk_q   <= 1'b1;
            buttons_q    <= '0;
        end else begin
            busy_q       <= busy_d;
            done_q       <= done_d;
            cont_latch_q <= cont_latch_d;
            cont_clk_q   <= cont_clk_d;
            buttons_q    <= buttons_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign cont_latch = cont_latch_q;
    assign cont_clk   = cont_clk_q;
    assign buttons    = buttons_q;

endmodule

// File: tb/tb_multi_controller_poller.sv
// Randomized self-checking bench: behavioural controller models drive the data pins,
// and expected button words and handshake timing are derived from the poll rules.
module tb_multi_controller_poller;

    localparam int N_CH = 2;
    localparam int BITS = 16;
    localparam int HD   = 4;
    localparam int LAT  = 1 + (2 + 2*BITS) * HD;
    localparam int LAT1 = 1 + (2 + 2*1) * HD;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 start = 1'b0;
    logic                 busy, done, cont_latch, cont_clk;
    logic [N_CH*BITS-1:0] buttons;
    logic [N_CH-1:0]      cont_data;

    logic                 start1 = 1'b0;
    logic                 busy1, done1, latch1, clk1;
    logic [0:0]           buttons1;
    logic [0:0]           data1;
    logic                 p1 = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multi_controller_poller #(.N_CH(N_CH), .BITS(BITS), .HALF_DIV(HD)) dut (
        .PCLK       (clk),
        .PRESERN    (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .buttons    (buttons),
        .cont_latch (cont_latch),
        .cont_clk   (cont_clk),
        .cont_data  (cont_data)
    );

    multi_controller_poller #(.N_CH(1), .BITS(1), .HALF_DIV(HD)) dut1 (
        .PCLK       (clk),
        .PRESERN    (rst_n),
        .start      (start1),
        .busy       (busy1),
        .done       (done1),
        .buttons    (buttons1),
        .cont_latch (latch1),
        .cont_clk   (clk1),
        .cont_data  (data1)
    );

    // Controller model: latch reloads bit 0, each rising shift clock advances one bit.
    logic [BITS-1:0] pressed [N_CH];
    int              ptr = 0;

    always @(posedge cont_latch or posedge cont_clk) begin
        if (cont_latch) ptr = 0;
        else            ptr = ptr + 1;
    end

    always_comb begin
        cont_data = '1;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (ptr < BITS) cont_data[ch] = ~pressed[ch][ptr];
        end
    end

    assign data1 = ~p1;

    logic [N_CH*BITS-1:0] shown = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N_CH*BITS-1:0] pack_pressed();
        logic [N_CH*BITS-1:0] w;
        for (int ch = 0; ch < N_CH; ch++) w[ch*BITS +: BITS] = pressed[ch];
        return w;
    endfunction

    // Caller is at a negedge. glitch: start pulses at bit 3 and in the DONE cycle.
    // chain: leave start high so the next poll is accepted on the edge after done.
    task automatic poll(input string tag, input bit glitch, input bit chain);
        int lat_hi = 0, falls = 0, dones = 0, busy_err = 0, hold_err = 0, quiet = 0;
        logic prev_clk;
        logic [N_CH*BITS-1:0] exp;
        exp   = pack_pressed();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        prev_clk = cont_clk;
        for (int n = 1; n <= LAT; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_err++;
            if (cont_latch === 1'b1) lat_hi++;
            if (prev_clk === 1'b1 && cont_clk === 1'b0) falls++;
            prev_clk = cont_clk;
            if (done === 1'b1) dones++;
            if (n < LAT && buttons !== shown) hold_err++;
            if (n == LAT) begin
                check({tag, "_done_edge"}, done, 1);
                check({tag, "_buttons"}, buttons, exp);
                shown = exp;
            end
            start = (glitch && (n == 33 || n == LAT - 1)) || (chain && n == LAT);
        end
        check({tag, "_busy_window"}, busy_err, 0);
        check({tag, "_latch_cycles"}, lat_hi, 2*HD);
        check({tag, "_clk_falls"}, falls, BITS);
        check({tag, "_done_count"}, dones, 1);
        check({tag, "_buttons_hold"}, hold_err, 0);
        if (!chain) begin
            repeat (4) begin
                @(negedge clk);
                if (busy !== 1'b0 || done !== 1'b0) quiet++;
            end
            check({tag, "_idle_after"}, quiet, 0);
        end
    endtask

    task automatic poll1(input logic val);
        int done_at = -1, dones = 0;
        p1     = val;
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        for (int n = 1; n <= LAT1 + 2; n++) begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                dones++;
                done_at = n;
                check("small_buttons", buttons1, val);
            end
        end
        check("small_done_edge", done_at, LAT1);
        check("small_done_count", dones, 1);
    endtask

    initial begin
        int gap, dones;
        for (int ch = 0; ch < N_CH; ch++) pressed[ch] = '0;

        // Reset with random inputs applied
        #1 rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            start  = 1'($urandom);
            start1 = 1'($urandom);
        end
        check("rst_cont_clk", cont_clk, 1);
        check("rst_cont_latch", cont_latch, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_buttons", buttons, 0);
        start  = 1'b0;
        start1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed poll with ignored starts, then accepted start on the edge after done
        pressed[0] = 16'h8001;
        pressed[1] = 16'h0000;
        poll("first", 1'b1, 1'b1);
        check("first_value", shown, 32'h0000_8001);
        pressed[0] = 16'($urandom);
        pressed[1] = 16'($urandom);
        poll("chained", 1'b0, 1'b0);

        // Reset in the middle of bit 5
        pressed[0] = 16'($urandom);
        pressed[1] = 16'($urandom);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat ((2 + 2*5) * HD) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_latch", cont_latch, 0);
        check("midrst_clk", cont_clk, 1);
        check("midrst_buttons", buttons, 0);
        shown = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (LAT + 10) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("midrst_no_done", dones, 0);
        pressed[0] = 16'h0000;
        pressed[1] = 16'h0004;
        poll("after_rst", 1'b0, 1'b0);
        check("after_rst_value", buttons, 32'h0004_0000);

        // Back-to-back polls with changed data
        pressed[0] = 16'h00FF;
        pressed[1] = 16'($urandom);
        poll("b2b_1", 1'b0, 1'b1);
        pressed[0] = 16'hFF00;
        poll("b2b_2", 1'b0, 1'b0);
        check("b2b_value", buttons[BITS-1:0], 16'hFF00);

        // Randomized polls
        for (int i = 0; i < 5; i++) begin
            pressed[0] = 16'($urandom);
            pressed[1] = 16'($urandom);
            gap = $urandom_range(0, 5);
            repeat (gap) @(negedge clk);
            poll("rand", 1'($urandom), 1'b0);
        end

        // Single-channel, single-bit instance
        poll1(1'b1);
        poll1(1'b0);
        poll1(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_controller_poller.md
# multi_controller_poller

Parametrised serial game-controller poller: drives a shared latch/clock pair to N_CH controllers, shifts BITS button bits from each controller's data line in parallel, and presents the decoded, active-high button state as one registered vector. Sits between the system clock domain (PCLK) and the controller connector pins, replacing the fixed single-channel clock divider. It adds phase timing, data capture, multi-channel support and a start/done handshake, so a bus wrapper can poll on demand.

## Interface
- N_CH, 2: number of controllers polled in parallel (≥1)
- BITS, 16: bits shifted per controller per poll (≥1)
- HALF_DIV, 300: PCLK cycles per protocol half-period (6 µs at 50 MHz; ≥4)
---
- PCLK  in  1  system clock; sole clock domain
- PRESERN  in  1  asynchronous, active-low reset
- start  in  1  poll request; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted through DONE inclusive
- done  out  1  one-cycle pulse; buttons updated on the same edge
- buttons  out  N_CH*BITS  bit [ch*BITS+k] = 1 when bit k of controller ch is pressed
- cont_latch  out  1  shared latch strobe, active high
- cont_clk  out  1  shared shift clock, idles high
- cont_data  in  N_CH  per-controller serial data, active low (0 = pressed)

## Operation
- States: IDLE, LATCH, CLK_LO, CLK_HI, DONE.
- A tick counter counts 0..HALF_DIV-1. It is cleared on start acceptance, and each wrap is one tick.
- IDLE → LATCH on start. Outputs: cont_latch=1, cont_clk=1. Holds for 2 ticks.
- LATCH → CLK_LO: cont_latch=0, cont_clk=0, 1 tick.
- CLK_LO → CLK_HI: cont_clk=1, 1 tick.
- CLK_HI → CLK_LO while bit index < BITS-1. Otherwise → DONE.
- DONE lasts 1 cycle: done=1, then → IDLE.
- cont_data passes through a 2-flop synchronizer, then the synchronized value is used for capture.
- Capture: on the edge that enters CLK_LO for bit k, each channel's synchronized data is inverted and stored into shadow bit k. Bit 0 is the first bit shifted.
- buttons is loaded from the shadow register only on the DONE edge. It otherwise holds, so updates are atomic.
- start while busy is ignored, not queued. This includes start in the DONE cycle.
- Bit index counter width is $clog2(BITS). It is not used outside CLK_LO/CLK_HI.

## Timing
- Reset values: cont_latch=0, cont_clk=1, busy=0, done=0, buttons=0, state=IDLE, counters=0.
- Assertion of PRESERN low mid-poll forces all outputs to their reset values asynchronously. No done is emitted.
- Latency: start accepted at edge 0, LATCH begins at edge 1, done=1 at edge 1+(2+2·BITS)·HALF_DIV.
- Latch width is 2·HALF_DIV cycles. Each cont_clk low and high phase is HALF_DIV cycles. There are exactly BITS falling edges per poll.
- Data settling: each bit is stable ≥HALF_DIV cycles before capture, which covers the 2-cycle synchronizer since HALF_DIV≥4.
- Minimum start-to-start period is 2+(2+2·BITS)·HALF_DIV cycles. Start in the cycle after done is accepted.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- controller_pkg: state enum, default parameter constants, and an elaboration check helper for HALF_DIV≥4, BITS≥1, N_CH≥1.
- Sub-module ctrl_tick_gen: parameter HALF_DIV, inputs PCLK/PRESERN/clear, output tick (one-cycle pulse every HALF_DIV cycles).
- The top contains the FSM, bit counter, synchronizers, N_CH shadow shift registers and the output register.

## Test plan
- Reset: hold PRESERN low with random inputs → cont_clk=1, cont_latch=0, busy=0, done=0, buttons=0.
- Single poll, N_CH=2, BITS=16, HALF_DIV=4:
  - Stimulus: ch0 model drives 0 on bits 0 and 15; ch1 is all 1.
  - Response: done at edge 137, buttons=32'h0000_8001, busy high edges 1–137.
  - Also check cont_latch high 8 cycles and 16 cont_clk falling edges.
- start pulsed at bit 3 and in the DONE cycle → ignored, exactly one done. start at edge 138 → new poll accepted.
- Reset mid-poll: assert PRESERN at bit 5, release, then poll with ch1 bit 2 pressed.
  - Outputs reset immediately, with no done.
  - The following poll gives buttons=32'h0004_0000.
- Back-to-back polls with changed data (poll 1 ch0=16'h00FF pressed, poll 2 ch0=16'hFF00) → buttons holds 16'h00FF during poll 2 and switches to 16'hFF00 exactly on the second done edge.
- N_CH=1, BITS=1, HALF_DIV=4: done at edge 17. A single pressed bit gives buttons=1'b1.
